// File: rtl/seq_shifter_pkg.sv
// Shared types for the multi-cycle shifter: shift mode encoding and FSM states.
// Mode 2'b10 is rotate-right only when SEQ_SHIFTER_ROTATE_EN is defined.
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_ROR = 2'b10,
    SHIFT_SRA = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One-cycle partial shift of 0..STEP bits, built as a power-of-two mux ladder.
// Rotate stages exist only when SEQ_SHIFTER_ROTATE_EN is defined; otherwise 2'b10 acts as SRL.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic [N-1:0]              data,
  input  logic [$clog2(STEP):0]     k,
  input  shift_mode_t               mode,
  input  logic                      fill,
  output logic [N-1:0]              result
);

  localparam int LK = $clog2(STEP) + 1;

  for (genvar i = 0; i < LK; i++) begin : g_stage
    localparam int SH = 1 << i;
    logic [N-1:0] din_s;
    logic [N-1:0] shifted_s;
    logic [N-1:0] dout_s;

    if (i == 0) begin : g_first
      assign din_s = data;
    end else begin : g_next
      assign din_s = g_stage[i-1].dout_s;
    end

    // Fixed SH-bit shift of this rung, filled according to the mode
    always_comb begin
      shifted_s = din_s;
      case (mode)
        SHIFT_SLL: shifted_s = {din_s[N-1-SH:0], {SH{1'b0}}};
        SHIFT_SRA: shifted_s = {{SH{fill}}, din_s[N-1:SH]};
`ifdef SEQ_SHIFTER_ROTATE_EN
        SHIFT_ROR: shifted_s = {din_s[SH-1:0], din_s[N-1:SH]};
`endif
        default:   shifted_s = {{SH{1'b0}}, din_s[N-1:SH]};
      endcase
    end

    assign dout_s = k[i] ? shifted_s : din_s;
  end

  assign result = g_stage[LK-1].dout_s;

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter, at most STEP bits per clock, valid/ready on both sides.
// Optional SEQ_SHIFTER_ROTATE_EN turns mode 2'b10 into rotate-right (default: behaves as SRL).
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_data,
  input  logic [$clog2(N)-1:0]  in_shamt,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_data,
  output logic                  busy
);

  localparam int SW = $clog2(N);
  localparam int KW = $clog2(STEP) + 1;

  state_t        state_r, next_state_s;
  logic [N-1:0]  data_r, data_nxt_s, step_out_s;
  logic [SW-1:0] rem_r, rem_nxt_s;
  shift_mode_t   mode_r, mode_nxt_s;
  logic          fill_r, fill_nxt_s;
  logic [KW-1:0] k_s;
  logic          accept_s;

  assign in_ready  = (state_r == S_IDLE) || ((state_r == S_DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_r == S_DONE);
  assign out_data  = data_r;
  assign busy      = (state_r != S_IDLE);

  // Clamp this cycle's step to what remains so rem can never underflow
  assign k_s = (rem_r > SW'(STEP)) ? KW'(STEP) : rem_r[KW-1:0];

  shift_step #(.N(N), .STEP(STEP)) u_shift_step (
    .data   (data_r),
    .k      (k_s),
    .mode   (mode_r),
    .fill   (fill_r),
    .result (step_out_s)
  );

  // Next-state and datapath update; DONE accepts a new request in the same cycle it retires one
  always_comb begin
    next_state_s = state_r;
    data_nxt_s   = data_r;
    rem_nxt_s    = rem_r;
    mode_nxt_s   = mode_r;
    fill_nxt_s   = fill_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          data_nxt_s   = in_data;
          rem_nxt_s    = in_shamt;
          mode_nxt_s   = shift_mode_t'(in_mode);
          fill_nxt_s   = in_data[N-1];
          next_state_s = (in_shamt == '0) ? S_DONE : S_SHIFT;
        end else if ((state_r == S_DONE) && out_ready) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      S_SHIFT: begin
        data_nxt_s = step_out_s;
        rem_nxt_s  = rem_r - SW'(k_s);
        if (rem_r <= SW'(STEP)) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_SHIFT;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // State and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      data_r  <= '0;
      rem_r   <= '0;
      mode_r  <= SHIFT_SLL;
      fill_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      data_r  <= data_nxt_s;
      rem_r   <= rem_nxt_s;
      mode_r  <= mode_nxt_s;
      fill_r  <= fill_nxt_s;
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (N=32, STEP=4): directed table, corner sequences, random ops.
// Expected results for mode 2'b10 follow SEQ_SHIFTER_ROTATE_EN.
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  seq_shifter #(.N(32), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  function automatic logic [31:0] ref_result(input logic [31:0] d, input logic [4:0] s,
                                             input logic [1:0] m);
    logic [63:0] dd;
    dd = {d, d} >> s;
    case (m)
      2'b00:   return d << s;
      2'b11:   return $unsigned($signed(d) >>> s);
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b10:   return dd[31:0];
`endif
      default: return d >> s;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] s);
    return (s == 5'd0) ? 1 : 1 + (int'(s) + 3) / 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for its result, optionally stall the consumer, then drain it.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                        input logic [31:0] exp_d, input int exp_lat, input int stall,
                        input string tag);
    int lat;
    in_data   = d;
    in_shamt  = s;
    in_mode   = m;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_mode  = 2'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    for (int j = 0; j < stall; j++) begin
      tick();
      check({tag, "_stall_data"}, out_data, exp_d);
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [4:0]  rs;
    logic [1:0]  rm;

    vecs.push_back('{32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF, 9});
    vecs.push_back('{32'hFFFF_FFFF, 5'd5,  2'b01, 32'h07FF_FFFF, 3});
    vecs.push_back('{32'hFFFF_FFFF, 5'd5,  2'b11, 32'hFFFF_FFFF, 3});
    vecs.push_back('{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1});
    vecs.push_back('{32'h1234_5678, 5'd4,  2'b00, 32'h2345_6780, 2});
`ifdef SEQ_SHIFTER_ROTATE_EN
    vecs.push_back('{32'h0000_0001, 5'd1,  2'b10, 32'h8000_0000, 2});
`else
    vecs.push_back('{32'h0000_0001, 5'd1,  2'b10, 32'h0000_0000, 2});
`endif
    vecs.push_back('{32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 2});
    vecs.push_back('{32'hF000_0000, 5'd8,  2'b11, 32'hFFF0_0000, 3});
    vecs.push_back('{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 9});
    vecs.push_back('{32'h7000_0000, 5'd3,  2'b11, 32'h0E00_0000, 2});

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_shamt  = 5'd0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_no_valid", 32'(out_valid), 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].data, vecs[i].shamt, vecs[i].mode, vecs[i].exp_data, vecs[i].exp_lat,
             0, $sformatf("vec%0d", i));

    // Backpressure then same-edge accept of the next request
    run_op(32'h1234_5678, 5'd4, 2'b00, 32'h2345_6780, 2, 5, "bp");
    in_data   = 32'h1234_5678;
    in_shamt  = 5'd4;
    in_mode   = 2'b00;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("bp2_valid", 32'(out_valid), 32'd1);
    in_data  = 32'h0000_0001;
    in_shamt = 5'd1;
    in_mode  = 2'b00;
    in_valid = 1'b1;
    #1;
    check("bp2_in_ready_stalled", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp2_in_ready_comb", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp2_shift_no_valid", 32'(out_valid), 32'd0);
    check("bp2_shift_busy", 32'(busy), 32'd1);
    tick();
    check("bp2_new_valid", 32'(out_valid), 32'd1);
    check("bp2_new_data", out_data, 32'h0000_0002);
    tick();
    check("bp2_idle", 32'(busy), 32'd0);

    // Reset mid-shift drops the transaction
    in_data  = 32'h8000_0000;
    in_shamt = 5'd31;
    in_mode  = 2'b11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_out_data", out_data, 32'h0);
    check("mid_busy", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("mid_in_ready", 32'(in_ready), 32'd1);
    for (int j = 0; j < 12; j++) begin
      tick();
      check("mid_no_stale", 32'(out_valid), 32'd0);
    end

    for (int i = 0; i < 200; i++) begin
      rd     = $urandom;
      rd[31] = (i % 2 == 0);
      rs     = 5'($urandom_range(0, 31));
      rm     = 2'($urandom_range(0, 3));
      run_op(rd, rs, rm, ref_result(rd, rs, rm), ref_latency(rs), $urandom_range(0, 2),
             $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
